// File: rtl/pipe_stage_buf.sv
// Pipeline stage register with valid/ready handshake: a head register backed by a
// small skid FIFO so in-flight payloads survive a downstream stall; flush kills all.
module pipe_stage_buf #(
  parameter int                 DATA_W     = 96,
  parameter int                 SKID_DEPTH = 2,
  parameter logic [DATA_W-1:0]  FLUSH_VAL  = '0,
  localparam int                CAP        = SKID_DEPTH + 1,
  localparam int                CW         = $clog2(CAP + 1)
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic [CW-1:0]     count
);

  localparam int PW = (SKID_DEPTH > 1) ? $clog2(SKID_DEPTH) : 1;

  logic [DATA_W-1:0] r_skid [SKID_DEPTH];
  logic [DATA_W-1:0] r_head_data;
  logic              r_head_valid;
  logic [PW-1:0]     r_rd_ptr;
  logic [PW-1:0]     r_wr_ptr;
  logic [CW-1:0]     r_count;

  logic              w_push;
  logic              w_pop;
  logic [CW-1:0]     w_skid_cnt;
  logic              w_skid_empty;
  logic              w_head_load;
  logic              w_push_to_skid;
  logic [PW-1:0]     w_rd_ptr_inc;
  logic [PW-1:0]     w_wr_ptr_inc;

  // in_ready depends on registered count only; a pop at full does not open a slot.
  assign in_ready       = (r_count != CW'(CAP));
  assign w_push         = in_valid & in_ready;
  assign w_pop          = r_head_valid & out_ready;
  assign w_skid_cnt     = r_count - CW'(r_head_valid);
  assign w_skid_empty   = (w_skid_cnt == '0);
  assign w_head_load    = ~r_head_valid | w_pop;
  assign w_push_to_skid = w_push & ~(w_head_load & w_skid_empty);

  // Explicit wrap so non-power-of-two depths cycle correctly.
  assign w_rd_ptr_inc = (r_rd_ptr == PW'(SKID_DEPTH - 1)) ? '0 : r_rd_ptr + 1'b1;
  assign w_wr_ptr_inc = (r_wr_ptr == PW'(SKID_DEPTH - 1)) ? '0 : r_wr_ptr + 1'b1;

  assign out_valid = r_head_valid;
  assign out_data  = r_head_data;
  assign count     = r_count;

  always_ff @(posedge CLK) begin
    if (w_push_to_skid) begin
      r_skid[r_wr_ptr] <= in_data;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST || flush) begin
      r_head_valid <= 1'b0;
      r_head_data  <= FLUSH_VAL;
      r_rd_ptr     <= '0;
      r_wr_ptr     <= '0;
      r_count      <= '0;
    end else begin
      if (w_head_load) begin
        if (!w_skid_empty) begin
          r_head_data  <= r_skid[r_rd_ptr];
          r_head_valid <= 1'b1;
          r_rd_ptr     <= w_rd_ptr_inc;
        end else if (w_push) begin
          r_head_data  <= in_data;
          r_head_valid <= 1'b1;
        end else begin
          r_head_valid <= 1'b0;
        end
      end
      if (w_push_to_skid) begin
        r_wr_ptr <= w_wr_ptr_inc;
      end
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      assert (r_count <= CW'(CAP));
      assert (r_head_valid == (r_count != '0));
      assert (!(w_push && (r_count == CW'(CAP))));
    end
  end

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Directed checks of pipe_stage_buf (depth 2) plus a queue-model run on a depth-3
// instance with a non-zero bubble value.
module tb_pipe_stage_buf;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic RST;

  logic        a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic [95:0] a_in_data, a_out_data;
  logic [1:0]  a_count;

  logic        b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [15:0] b_in_data, b_out_data;
  logic [2:0]  b_count;

  pipe_stage_buf u_dut_a (
    .CLK(CLK), .RST(RST), .flush(a_flush),
    .in_valid(a_in_valid), .in_data(a_in_data), .in_ready(a_in_ready),
    .out_valid(a_out_valid), .out_data(a_out_data), .out_ready(a_out_ready),
    .count(a_count)
  );

  pipe_stage_buf #(.DATA_W(16), .SKID_DEPTH(3), .FLUSH_VAL(16'hF0F0)) u_dut_b (
    .CLK(CLK), .RST(RST), .flush(b_flush),
    .in_valid(b_in_valid), .in_data(b_in_data), .in_ready(b_in_ready),
    .out_valid(b_out_valid), .out_data(b_out_data), .out_ready(b_out_ready),
    .count(b_count)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  logic [15:0] q[$];
  logic [15:0] last;
  int          wr_model;
  int          wraps;
  int          skid_cnt;
  logic        m_push, m_pop, to_head;

  initial begin
    RST = 1'b1;
    a_flush = 1'b0; a_in_valid = 1'b1; a_in_data = 96'h55; a_out_ready = 1'b0;
    b_flush = 1'b0; b_in_valid = 1'b1; b_in_data = 16'h55; b_out_ready = 1'b0;

    // 1: reset with in_valid high
    tick(); tick();
    chk("rst_valid", 96'(a_out_valid), 96'd0);
    chk("rst_data",  a_out_data, 96'd0);
    chk("rst_count", 96'(a_count), 96'd0);
    chk("rst_ready", 96'(a_in_ready), 96'd1);
    chk("rst_b_data", 96'(b_out_data), 96'hF0F0);
    RST = 1'b0; a_in_valid = 1'b0; b_in_valid = 1'b0;

    // 2: streaming, one in one out per cycle
    a_out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      a_in_valid = 1'b1; a_in_data = 96'(i);
      chk("stream_ready", 96'(a_in_ready), 96'd1);
      tick();
      chk("stream_data",  a_out_data, 96'(i));
      chk("stream_valid", 96'(a_out_valid), 96'd1);
      chk("stream_count", 96'(a_count), 96'd1);
      $display("stream push=%0h out=%0h count=%0d", i, a_out_data, a_count);
    end
    a_in_valid = 1'b0;
    tick();
    chk("stream_drain_count", 96'(a_count), 96'd0);
    chk("stream_drain_valid", 96'(a_out_valid), 96'd0);
    chk("stream_hold_data",   a_out_data, 96'h8);

    // 3: stall fill, 0xD held upstream, then ordered release
    a_out_ready = 1'b0; a_in_valid = 1'b1;
    a_in_data = 96'hA; tick();
    a_in_data = 96'hB; tick();
    a_in_data = 96'hC; tick();
    chk("fill_count", 96'(a_count), 96'd3);
    chk("fill_ready", 96'(a_in_ready), 96'd0);
    chk("fill_head",  a_out_data, 96'hA);
    a_in_data = 96'hD; tick();
    chk("stall_count", 96'(a_count), 96'd3);
    chk("stall_head",  a_out_data, 96'hA);
    a_out_ready = 1'b1; tick();
    chk("rel1_data",  a_out_data, 96'hB);
    chk("rel1_count", 96'(a_count), 96'd2);
    chk("rel1_ready", 96'(a_in_ready), 96'd1);
    tick();
    chk("rel2_data",  a_out_data, 96'hC);
    chk("rel2_count", 96'(a_count), 96'd2);
    a_in_valid = 1'b0; tick();
    chk("rel3_data",  a_out_data, 96'hD);
    chk("rel3_count", 96'(a_count), 96'd1);
    tick();
    chk("rel4_count", 96'(a_count), 96'd0);
    $display("stall release done count=%0d", a_count);

    // 4: pop at full does not admit the same-cycle push
    a_out_ready = 1'b0; a_in_valid = 1'b1;
    a_in_data = 96'h1; tick();
    a_in_data = 96'h2; tick();
    a_in_data = 96'h3; tick();
    a_out_ready = 1'b1; a_in_data = 96'h4; tick();
    chk("fullpop_count", 96'(a_count), 96'd2);
    chk("fullpop_ready", 96'(a_in_ready), 96'd1);
    chk("fullpop_head",  a_out_data, 96'h2);
    a_out_ready = 1'b0; tick();
    chk("fullpop_push_count", 96'(a_count), 96'd3);
    a_in_valid = 1'b0; a_out_ready = 1'b1;
    tick(); chk("fullpop_d1", a_out_data, 96'h3);
    tick(); chk("fullpop_d2", a_out_data, 96'h4);
    tick(); chk("fullpop_empty", 96'(a_count), 96'd0);

    // 5: flush at full with a push and pop offered
    a_out_ready = 1'b0; a_in_valid = 1'b1;
    a_in_data = 96'h11; tick();
    a_in_data = 96'h22; tick();
    a_in_data = 96'h33; tick();
    chk("preflush_count", 96'(a_count), 96'd3);
    a_flush = 1'b1; a_out_ready = 1'b1; a_in_data = 96'h99; tick();
    chk("flush_count", 96'(a_count), 96'd0);
    chk("flush_valid", 96'(a_out_valid), 96'd0);
    chk("flush_data",  a_out_data, 96'd0);
    chk("flush_ready", 96'(a_in_ready), 96'd1);
    a_flush = 1'b0; a_in_valid = 1'b0; tick();
    chk("postflush_valid", 96'(a_out_valid), 96'd0);
    chk("postflush_data",  a_out_data, 96'd0);
    $display("flush done count=%0d out=%0h", a_count, a_out_data);

    // 6: depth-3 random stall/push against a queue model
    last = 16'hF0F0; wr_model = 0; wraps = 0;
    for (int c = 0; c < 80; c++) begin
      b_in_valid  = ($urandom_range(9) < 8);
      b_in_data   = 16'($urandom);
      b_out_ready = 1'($urandom_range(1));
      chk("rnd_count", 96'(b_count), 96'(q.size()));
      chk("rnd_ready", 96'(b_in_ready), 96'(q.size() != 4));
      chk("rnd_valid", 96'(b_out_valid), 96'(q.size() != 0));
      chk("rnd_data",  96'(b_out_data), 96'(last));
      m_push   = b_in_valid && (q.size() != 4);
      m_pop    = (q.size() != 0) && b_out_ready;
      skid_cnt = (q.size() > 0) ? q.size() - 1 : 0;
      to_head  = ((q.size() == 0) || m_pop) && (skid_cnt == 0);
      if (m_push && !to_head) begin
        if (wr_model == 2) begin
          wr_model = 0;
          wraps++;
        end else begin
          wr_model++;
        end
      end
      if (m_pop) void'(q.pop_front());
      if (m_push) q.push_back(b_in_data);
      if (q.size() != 0) last = q[0];
      $display("rnd c=%0d v=%0b d=%h r=%0b out=%h cnt=%0d", c, b_in_valid, b_in_data,
               b_out_ready, b_out_data, b_count);
      tick();
    end
    chk("rnd_wrap_cover", 96'(wraps >= 4), 96'd1);
    b_in_valid = 1'b0; b_flush = 1'b1; tick();
    chk("b_flush_data",  96'(b_out_data), 96'hF0F0);
    chk("b_flush_count", 96'(b_count), 96'd0);
    b_flush = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
